// File: rtl/instr_loader_if.sv
// Loader bus bundle: UART byte input plus instruction-memory write port and status.
// Ports: master (byte source / memory side), slave (the loader).
// Signal names keep the _i/_o direction as seen from the loader.
interface instr_loader_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) ();
  logic                 load_start_i;
  logic                 rx_valid_i;
  logic [7:0]           rx_data_i;
  logic                 en_write_o;
  logic [NB_ADDR-1:0]   addr_write_o;
  logic [NB_DATA-1:0]   data_o;
  logic                 loading_o;
  logic                 load_done_o;
  logic                 overflow_o;
  logic [NB_ADDR-2:0]   words_loaded_o;

  modport master (
    output load_start_i, rx_valid_i, rx_data_i,
    input  en_write_o, addr_write_o, data_o, loading_o, load_done_o,
           overflow_o, words_loaded_o
  );

  modport slave (
    input  load_start_i, rx_valid_i, rx_data_i,
    output en_write_o, addr_write_o, data_o, loading_o, load_done_o,
           overflow_o, words_loaded_o
  );
endinterface

// File: rtl/instr_loader.sv
// Program loader: packs UART bytes MSB-first into 32-bit words and writes them to
// consecutive word addresses until a HALT word or the last address, then flags DONE.
// Ports: clock_i, reset_i (async, active-high), ldr_io (instr_loader_if.slave).
module instr_loader #(
  parameter int                 NB_DATA   = 32,   // 4 bytes per word
  parameter int                 NB_ADDR   = 7,
  parameter int                 ADDR_STEP = 4,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic           clock_i,
  input  logic           reset_i,
  instr_loader_if.slave  ldr_io
);

  localparam int LAST_IDX = (2 ** NB_ADDR) / ADDR_STEP - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [1:0]           byte_cnt_q;
  logic [NB_ADDR-1:0]   word_idx_q;
  logic [NB_DATA-1:0]   shift_q;
  logic                 last_pend_q;   // the write pulse now on the bus ends the load
  logic                 en_write_q;
  logic [NB_ADDR-1:0]   addr_q;
  logic [NB_DATA-1:0]   data_q;
  logic                 loading_q;
  logic                 done_q;
  logic                 overflow_q;
  logic [NB_ADDR-2:0]   words_q;

  // Word completed by the byte arriving this cycle.
  logic [NB_DATA-1:0]   word_d;
  assign word_d = {shift_q[NB_DATA-9:0], ldr_io.rx_data_i};

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      shift_q     <= '0;
      last_pend_q <= 1'b0;
      en_write_q  <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      loading_q   <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      en_write_q <= 1'b0;
      if (ldr_io.load_start_i) begin
        // (Re)start from any state; a same-cycle byte and any partial word are dropped.
        state_q     <= LOAD;
        loading_q   <= 1'b1;
        done_q      <= 1'b0;
        byte_cnt_q  <= '0;
        word_idx_q  <= '0;
        shift_q     <= '0;
        last_pend_q <= 1'b0;
        overflow_q  <= 1'b0;
        words_q     <= '0;
      end else if (state_q == LOAD) begin
        // Counters advance in the cycle after the write pulse is presented.
        if (en_write_q) begin
          words_q    <= words_q + 1'b1;
          word_idx_q <= word_idx_q + 1'b1;
        end
        if (en_write_q && last_pend_q) begin
          // Final pulse completes: bytes arriving now are dropped.
          state_q     <= DONE;
          loading_q   <= 1'b0;
          done_q      <= 1'b1;
          last_pend_q <= 1'b0;
          overflow_q  <= (data_q != HALT_WORD);
        end else if (ldr_io.rx_valid_i) begin
          shift_q    <= word_d;
          byte_cnt_q <= byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            data_q      <= word_d;
            addr_q      <= NB_ADDR'(word_idx_q * ADDR_STEP);
            en_write_q  <= 1'b1;
            last_pend_q <= (word_d == HALT_WORD) ||
                           (word_idx_q == NB_ADDR'(LAST_IDX));
          end
        end
      end
    end
  end

  assign ldr_io.en_write_o     = en_write_q;
  assign ldr_io.addr_write_o   = addr_q;
  assign ldr_io.data_o         = data_q;
  assign ldr_io.loading_o      = loading_q;
  assign ldr_io.load_done_o    = done_q;
  assign ldr_io.overflow_o     = overflow_q;
  assign ldr_io.words_loaded_o = words_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed and randomized byte streams
// compared against a word-level reference model of the load rules.
// Ports: none (top-level bench).
module tb_instr_loader;
  localparam int          NB_DATA   = 32;
  localparam int          NB_ADDR   = 7;
  localparam int          ADDR_STEP = 4;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
  localparam int          MAX_W     = (2 ** NB_ADDR) / ADDR_STEP;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  instr_loader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) ldr_if ();

  instr_loader #(
    .NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .ADDR_STEP(ADDR_STEP), .HALT_WORD(HALT)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .ldr_io  (ldr_if.slave)
  );

  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // Write-pulse monitor, sampled on the falling edge.
  logic [31:0]        mon_d[$];
  logic [NB_ADDR-1:0] mon_a[$];
  int                 mon_c[$];
  always @(negedge clock_i) begin
    if (ldr_if.en_write_o === 1'b1) begin
      mon_d.push_back(ldr_if.data_o);
      mon_a.push_back(ldr_if.addr_write_o);
      mon_c.push_back(cyc);
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: bytes of the current load -> expected writes.
  byte unsigned stim[$];
  logic [31:0]  exp_w[$];
  bit           exp_ovf;
  bit           exp_done;

  task automatic model_run();
    logic [31:0] w;
    exp_w.delete();
    exp_ovf  = 0;
    exp_done = 0;
    for (int i = 0; i < stim.size() / 4 && !exp_done; i++) begin
      w = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
      exp_w.push_back(w);
      if (w == HALT) exp_done = 1;
      else if (exp_w.size() == MAX_W) begin
        exp_done = 1;
        exp_ovf  = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_mon();
    mon_d.delete();
    mon_a.delete();
    mon_c.delete();
  endtask

  task automatic do_start();
    ldr_if.load_start_i = 1'b1;
    tick();
    ldr_if.load_start_i = 1'b0;
  endtask

  task automatic send_stim(input int max_gap);
    foreach (stim[i]) begin
      ldr_if.rx_valid_i = 1'b1;
      ldr_if.rx_data_i  = stim[i];
      tick();
      ldr_if.rx_valid_i = 1'b0;
      ldr_if.rx_data_i  = 8'h00;
      repeat ($urandom_range(0, max_gap)) tick();
    end
    repeat (3) tick();
  endtask

  task automatic push_word(input logic [31:0] w);
    stim.push_back(w[31:24]);
    stim.push_back(w[23:16]);
    stim.push_back(w[15:8]);
    stim.push_back(w[7:0]);
  endtask

  // Compare monitored writes and final status against the model.
  task automatic check_load(input string tag, input bit back_to_back);
    int n;
    model_run();
    chk({tag, ".nwrites"}, mon_d.size(), exp_w.size());
    n = (mon_d.size() < exp_w.size()) ? mon_d.size() : exp_w.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.data%0d", tag, i), mon_d[i], exp_w[i]);
      chk($sformatf("%s.addr%0d", tag, i), mon_a[i], (i * ADDR_STEP) % (2 ** NB_ADDR));
      if (i > 0) begin
        if (back_to_back) chk($sformatf("%s.gap%0d", tag, i), mon_c[i] - mon_c[i-1], 4);
        else chk($sformatf("%s.mingap%0d", tag, i), (mon_c[i] - mon_c[i-1]) >= 4, 1);
      end
    end
    chk({tag, ".done"},     ldr_if.load_done_o,    exp_done);
    chk({tag, ".loading"},  ldr_if.loading_o,      !exp_done);
    chk({tag, ".overflow"}, ldr_if.overflow_o,     exp_ovf);
    chk({tag, ".words"},    ldr_if.words_loaded_o, exp_w.size() % (2 ** (NB_ADDR - 1)));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".en"},   ldr_if.en_write_o,     0);
    chk({tag, ".addr"}, ldr_if.addr_write_o,   0);
    chk({tag, ".data"}, ldr_if.data_o,         0);
    chk({tag, ".load"}, ldr_if.loading_o,      0);
    chk({tag, ".done"}, ldr_if.load_done_o,    0);
    chk({tag, ".ovf"},  ldr_if.overflow_o,     0);
    chk({tag, ".cnt"},  ldr_if.words_loaded_o, 0);
  endtask

  initial begin
    logic [31:0] w;
    int          k;

    ldr_if.load_start_i = 1'b0;
    ldr_if.rx_valid_i   = 1'b0;
    ldr_if.rx_data_i    = 8'h00;

    // Reset state.
    repeat (2) tick();
    check_all_zero("reset");
    reset_i = 1'b0;
    tick();

    // Bytes while IDLE are ignored.
    clear_mon();
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stim(0);
    chk("idle.nwrites", mon_d.size(), 0);
    check_all_zero("idle");

    // Basic load ending in HALT.
    clear_mon();
    do_start();
    chk("start.loading", ldr_if.loading_o, 1);
    stim = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_stim(0);
    check_load("halt", 1);

    // Bytes in DONE are ignored.
    clear_mon();
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_stim(0);
    chk("done_rx.nwrites", mon_d.size(), 0);
    chk("done_rx.words", ldr_if.words_loaded_o, 3);
    chk("done_rx.done", ldr_if.load_done_o, 1);

    // Randomized loads, random byte spacing, terminated by HALT.
    for (int r = 0; r < 4; r++) begin
      clear_mon();
      do_start();
      stim.delete();
      k = $urandom_range(1, 8);
      for (int j = 0; j < k - 1; j++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        push_word(w);
      end
      push_word(HALT);
      send_stim(r % 3);
      check_load($sformatf("rand%0d", r), r % 3 == 0);
    end

    // Memory full without HALT; a 33rd word follows immediately.
    clear_mon();
    do_start();
    stim.delete();
    for (int j = 1; j <= MAX_W + 1; j++) push_word(32'(j));
    send_stim(0);
    check_load("full", 1);
    if (mon_c.size() == MAX_W) chk("full.span", mon_c[MAX_W-1] - mon_c[0], 124);

    // Partial word discarded on restart.
    clear_mon();
    do_start();
    stim = '{8'hA1, 8'hA2};
    send_stim(0);
    do_start();
    stim = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_stim(0);
    check_load("partial", 1);

    // Start and byte in the same cycle: the byte is dropped.
    clear_mon();
    ldr_if.load_start_i = 1'b1;
    ldr_if.rx_valid_i   = 1'b1;
    ldr_if.rx_data_i    = 8'h55;
    tick();
    ldr_if.load_start_i = 1'b0;
    ldr_if.rx_valid_i   = 1'b0;
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_stim(0);
    check_load("start_rx", 1);

    // Asynchronous reset between bytes 2 and 3 of the first word.
    clear_mon();
    do_start();
    stim = '{8'hC1, 8'hC2};
    send_stim(0);
    #2 reset_i = 1'b1;
    #1 check_all_zero("arst");
    tick();
    reset_i = 1'b0;
    tick();
    stim = '{8'hC3, 8'hC4, 8'h10, 8'h20, 8'h30, 8'h40};
    send_stim(0);
    chk("arst.nwrites", mon_d.size(), 0);
    check_all_zero("post_arst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that sits directly upstream of the fetch stage and drives its instruction-memory write port (`en_write_i`, `addr_i_write`, `data_i`).
- Receives a byte stream from the UART receiver and packs each group of 4 bytes MSB-first into a 32-bit instruction word.
- Writes each word to consecutive word-aligned addresses (step 4).
- Stops on a HALT word or when memory is full, then raises `load_done_o` so the debug unit can enable the pipeline.

## Interface
- `NB_DATA`, 32, instruction width; must be 4×8.
- `NB_ADDR`, 7, instruction-memory address width.
- `ADDR_STEP`, 4, address increment per written word.
- `HALT_WORD`, 32'hFFFF_FFFF, word that terminates a load; it is still written to memory.

Ports:
- `clock_i`  in  1  system clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `load_start_i`  in  1  one-cycle pulse; begins or restarts a load.
- `rx_valid_i`  in  1  one-cycle strobe; `rx_data_i` is valid.
- `rx_data_i`  in  8  received byte.
- `en_write_o`  out  1  write strobe to instruction memory.
- `addr_write_o`  out  NB_ADDR  write address.
- `data_o`  out  NB_DATA  assembled instruction word.
- `loading_o`  out  1  high while in LOAD.
- `load_done_o`  out  1  high while in DONE.
- `overflow_o`  out  1  load ended because memory filled without a HALT word.
- `words_loaded_o`  out  NB_ADDR-1  count of words written in the current or last load (6 bits for the defaults).

## Operation
- FSM states:
  - IDLE: reset state.
  - LOAD: collecting bytes.
  - DONE: load finished.
- Transitions:
  - IDLE → LOAD on `load_start_i`.
  - LOAD → DONE after the final write pulse completes (see Timing).
  - DONE → LOAD on `load_start_i`.
  - `load_start_i` in LOAD restarts the load.
- Every entry into LOAD clears:
  - byte counter (2 bits)
  - word index
  - `words_loaded_o`
  - `overflow_o`
  - shift register
- Byte packing in LOAD: each `rx_valid_i` shifts `rx_data_i` into the low byte of a 32-bit shift register. The first byte of a word ends up in bits 31:24 after 4 bytes. The byte counter increments, wrapping 3→0.
- On the 4th byte of a word:
  - the complete word is registered to `data_o`;
  - `addr_write_o` = word_index × ADDR_STEP, truncated to NB_ADDR bits;
  - `en_write_o` is set for exactly one cycle;
  - word_index and `words_loaded_o` then increment.
- Last word is either the HALT word or the word written at the last address (word_index = 2^NB_ADDR/ADDR_STEP − 1 = 31). After the last word:
  - FSM goes to DONE;
  - `overflow_o` = 1 only if the last word is not HALT_WORD;
  - bytes arriving in the same cycle as the final write pulse are dropped.
- `rx_valid_i` in IDLE or DONE is ignored; state, counters and outputs are unchanged.
- `load_start_i` and `rx_valid_i` in the same cycle: the restart wins and the byte is dropped.
- A partial word (1–3 bytes) is discarded on restart and never written.
- `data_o` and `addr_write_o` hold their last values when `en_write_o` = 0.

## Timing
- Reset values (asynchronous, effective immediately):
  - state = IDLE
  - `en_write_o` = 0
  - `addr_write_o` = 0
  - `data_o` = 0
  - `loading_o` = 0
  - `load_done_o` = 0
  - `overflow_o` = 0
  - `words_loaded_o` = 0
  - internal counters = 0
- Reset mid-load aborts the load. Memory writes already issued are not undone.
- Start latency: `load_start_i` sampled at edge N → `loading_o` = 1 from N.
- Write latency: 4th byte sampled at edge N → `en_write_o`, `data_o` and `addr_write_o` valid during the cycle after N; `en_write_o` falls at N+1.
- Counter update: `words_loaded_o` increments at N+1.
- Completion: the final write pulse is in the cycle after N → at edge N+1, state = DONE, `loading_o` = 0, `load_done_o` = 1, `overflow_o` valid.
- Byte rate: back-to-back `rx_valid_i` on every cycle is supported. The next word's bytes may be accepted while `en_write_o` is high. Minimum spacing between write pulses is 4 cycles.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset then IDLE: drive bytes AA,BB,CC,DD with no start → `en_write_o` never pulses, all outputs 0.
- Start, then bytes 12,34,56,78, 9A,BC,DE,F0, FF,FF,FF,FF → pulses expected:
  - 0x12345678 @ 0
  - 0x9ABCDEF0 @ 4
  - 0xFFFFFFFF @ 8
  - then DONE, `words_loaded_o` = 3, `overflow_o` = 0.
- 32 non-HALT words (0x00000001…0x00000020) sent back-to-back every cycle:
  - last write is 0x00000020 @ 124;
  - DONE with `overflow_o` = 1, `words_loaded_o` = 32 mod 64 = 32;
  - a 33rd word is ignored.
- Partial word: send 2 bytes, pulse `load_start_i`, then 11,22,33,44 → single write 0x11223344 @ 0.
- `load_start_i` together with `rx_valid_i` (byte 55), then 01,02,03,04 → write 0x01020304 @ 0; 0x55 appears nowhere.
- Assert `reset_i` between the 2nd and 3rd bytes of word 1:
  - all outputs return to 0 immediately;
  - subsequent bytes are ignored until a new `load_start_i`.
